// File: rtl/decode_pkg.sv
// Shared opcode/funct constants and instruction field-position helpers
// for the MIPS decode stage.
package decode_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] SLTIU  = 6'h0B;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] JR     = 6'h08;

  localparam int DEF_NB_DATA   = 32;
  localparam int DEF_NB_ADDR   = 5;
  localparam int DEF_NB_OPCODE = 6;

  // imm occupies everything below rs/rt; rt sits just above it.
  function automatic int imm_width(
    input int nb_data,
    input int nb_opcode,
    input int nb_addr
  );
    return nb_data - nb_opcode - 2 * nb_addr;
  endfunction

  function automatic int rt_lsb(
    input int nb_data,
    input int nb_opcode,
    input int nb_addr
  );
    return imm_width(nb_data, nb_opcode, nb_addr);
  endfunction

  function automatic int rs_lsb(
    input int nb_data,
    input int nb_opcode,
    input int nb_addr
  );
    return imm_width(nb_data, nb_opcode, nb_addr) + nb_addr;
  endfunction

  localparam int DEF_IMM_W =
    imm_width(DEF_NB_DATA, DEF_NB_OPCODE, DEF_NB_ADDR);

endpackage

// File: rtl/decode_stage_hz_regfile.sv
// 2-read / 1-write register file with r0 hardwired to zero,
// write-through read bypass and synchronous clear.
module register_file_bypass #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_ADDR-1:0] i_rd_addr_a,
  input  logic [NB_ADDR-1:0] i_rd_addr_b,
  output logic [NB_DATA-1:0] o_rd_data_a,
  output logic [NB_DATA-1:0] o_rd_data_b,
  input  logic               i_wr_enable,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic               wr_ok;

  assign wr_ok = i_wr_enable && (i_wr_addr != '0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // r0 check comes first so a write to r0 never leaks through the bypass
  assign o_rd_data_a =
    (i_rd_addr_a == '0) ? '0 :
    (wr_ok && i_wr_addr == i_rd_addr_a) ? i_wr_data :
    mem[i_rd_addr_a];

  assign o_rd_data_b =
    (i_rd_addr_b == '0) ? '0 :
    (wr_ok && i_wr_addr == i_rd_addr_b) ? i_wr_data :
    mem[i_rd_addr_b];

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS decode stage: field decode, register read, load-use hazard,
// in-stage BEQ/BNE resolution and the ID/EX pipeline register.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = 5,
  parameter int NB_PC     = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_SA     = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_DATA-1:0]   i_instruction,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic                 i_flush,
  input  logic                 i_wb_wr_enable,
  input  logic [NB_ADDR-1:0]   i_wb_wr_addr,
  input  logic [NB_DATA-1:0]   i_wb_data,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_reg_write,
  input  logic [NB_ADDR-1:0]   i_ex_wr_addr,
  output logic                 o_stall,
  output logic                 o_branch_taken,
  output logic [NB_PC-1:0]     o_branch_target,
  output logic                 o_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [NB_DATA-1:0]   o_rs_data,
  output logic [NB_DATA-1:0]   o_rt_data,
  output logic [NB_DATA-1:0]   o_imm,
  output logic [NB_ADDR-1:0]   o_rs_addr,
  output logic [NB_ADDR-1:0]   o_rt_addr,
  output logic [NB_ADDR-1:0]   o_wr_addr,
  output logic [NB_SA-1:0]     o_sa,
  output logic [NB_OPCODE-1:0] o_alu_ctrl_opcode,
  output logic [NB_PC-1:0]     o_pc
);

  localparam int NB_IMM = imm_width(NB_DATA, NB_OPCODE, NB_ADDR);
  localparam int RT_LSB = rt_lsb(NB_DATA, NB_OPCODE, NB_ADDR);
  localparam int RS_LSB = rs_lsb(NB_DATA, NB_OPCODE, NB_ADDR);
  localparam int SA_LSB = NB_OPCODE;
  localparam int RD_LSB = NB_OPCODE + NB_SA;

  logic [NB_OPCODE-1:0] opcode;
  logic [NB_OPCODE-1:0] funct;
  logic [NB_ADDR-1:0]   rs;
  logic [NB_ADDR-1:0]   rt;
  logic [NB_ADDR-1:0]   rd;
  logic [NB_SA-1:0]     sa;
  logic [NB_IMM-1:0]    imm;

  assign opcode = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign rs     = i_instruction[RS_LSB +: NB_ADDR];
  assign rt     = i_instruction[RT_LSB +: NB_ADDR];
  assign rd     = i_instruction[RD_LSB +: NB_ADDR];
  assign sa     = i_instruction[SA_LSB +: NB_SA];
  assign funct  = i_instruction[NB_OPCODE-1:0];
  assign imm    = i_instruction[NB_IMM-1:0];

  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;

  register_file_bypass #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_regfile (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rd_addr_a (rs),
    .i_rd_addr_b (rt),
    .o_rd_data_a (rs_data),
    .o_rd_data_b (rt_data),
    .i_wr_enable (i_wb_wr_enable),
    .i_wr_addr   (i_wb_wr_addr),
    .i_wr_data   (i_wb_data)
  );

  logic is_r, is_alu_i, is_lw, is_sw, is_beq, is_bne, zext;

  assign is_r     = (opcode == R_TYPE);
  assign is_alu_i = (opcode >= ADDI) && (opcode <= LUI);
  assign is_lw    = (opcode == LW);
  assign is_sw    = (opcode == SW);
  assign is_beq   = (opcode == BEQ);
  assign is_bne   = (opcode == BNE);
  assign zext     = (opcode >= ANDI) && (opcode <= LUI);

  logic [NB_DATA-1:0] imm_ext;

  assign imm_ext = zext ?
    {{(NB_DATA-NB_IMM){1'b0}}, imm} :
    {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm};

  logic                 dec_rw, dec_mr, dec_mw;
  logic [NB_ADDR-1:0]   dec_wr;
  logic [NB_OPCODE-1:0] dec_alu;

  always_comb begin
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wr  = rt;
    dec_alu = opcode;
    unique case (1'b1)
      is_r: begin
        dec_alu = funct;
        dec_wr  = rd;
        dec_rw  = (funct != JR);
      end
      is_alu_i: dec_rw = 1'b1;
      is_lw: begin
        dec_rw = 1'b1;
        dec_mr = 1'b1;
      end
      is_sw: dec_mw = 1'b1;
      default: ;
    endcase
  end

  // Branches compare in ID, so any EX producer must wait, not just loads
  logic ex_hit;

  assign ex_hit = (i_ex_wr_addr != '0) &&
                  ((i_ex_wr_addr == rs) || (i_ex_wr_addr == rt));

  assign o_stall = i_valid && i_ex_reg_write && ex_hit &&
                   (i_ex_mem_read || is_beq || is_bne);

  logic               eq;
  logic [NB_PC-1:0]   br_off;

  assign eq     = (rs_data == rt_data);
  assign br_off = {{(NB_PC-NB_IMM-2){imm[NB_IMM-1]}}, imm, 2'b00};

  assign o_branch_target = i_pc + br_off;
  assign o_branch_taken  = i_valid && !o_stall && !i_flush &&
                           ((is_beq && eq) || (is_bne && !eq));

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush || o_stall) begin
      o_valid           <= 1'b0;
      o_reg_write       <= 1'b0;
      o_mem_read        <= 1'b0;
      o_mem_write       <= 1'b0;
      o_rs_data         <= '0;
      o_rt_data         <= '0;
      o_imm             <= '0;
      o_rs_addr         <= '0;
      o_rt_addr         <= '0;
      o_wr_addr         <= '0;
      o_sa              <= '0;
      o_alu_ctrl_opcode <= '0;
      o_pc              <= '0;
    end else begin
      o_valid           <= i_valid;
      o_reg_write       <= i_valid && dec_rw;
      o_mem_read        <= i_valid && dec_mr;
      o_mem_write       <= i_valid && dec_mw;
      o_rs_data         <= rs_data;
      o_rt_data         <= rt_data;
      o_imm             <= imm_ext;
      o_rs_addr         <= rs;
      o_rt_addr         <= rt;
      o_wr_addr         <= dec_wr;
      o_sa              <= sa;
      o_alu_ctrl_opcode <= dec_alu;
      o_pc              <= i_pc;
    end
  end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Second-generation MIPS instruction-decode stage with a fully parametrised datapath. It sits between the IF/ID pipeline register and the execute stage, and adds the following over the first-generation decoder:
- a write-through register file;
- load-use hazard detection with stall;
- flush support;
- per-instruction valid tracking;
- in-stage BEQ/BNE resolution;
- opcode-dependent sign/zero immediate extension.

All ID/EX outputs are registered and resettable.

## Interface
- NB_DATA, 32, datapath and instruction width
- NB_ADDR, 5, register address width (register file has 2**NB_ADDR entries)
- NB_PC, 32, program-counter width
- NB_OPCODE, 6, opcode/funct field width (also ALU control width)
- NB_SA, 5, shift-amount field width

Ports:
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  synchronous, active-high
- i_valid  in  1  IF/ID slot holds a real instruction
- i_instruction  in  NB_DATA  IF/ID instruction word
- i_pc  in  NB_PC  PC+4 of the instruction
- i_flush  in  1  kill the instruction entering ID/EX
- i_wb_wr_enable  in  1  writeback write strobe
- i_wb_wr_addr  in  NB_ADDR  writeback destination
- i_wb_data  in  NB_DATA  writeback data
- i_ex_mem_read  in  1  instruction currently in EX is a load
- i_ex_reg_write  in  1  instruction in EX writes a register
- i_ex_wr_addr  in  NB_ADDR  EX destination register
- o_stall  out  1  combinational; hold PC and IF/ID
- o_branch_taken  out  1  combinational; redirect fetch
- o_branch_target  out  NB_PC  combinational; i_pc + (sign-extended imm << 2)
- o_valid, o_reg_write, o_mem_read, o_mem_write  out  1 each  ID/EX control
- o_rs_data, o_rt_data, o_imm  out  NB_DATA  ID/EX operands
- o_rs_addr, o_rt_addr, o_wr_addr  out  NB_ADDR  ID/EX register addresses
- o_sa  out  NB_SA  ID/EX shift amount
- o_alu_ctrl_opcode  out  NB_OPCODE  ID/EX ALU control
- o_pc  out  NB_PC  ID/EX PC+4

## Operation

Field decode:
- opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], sa = [10:6], funct = [5:0], imm = [15:0].
- Fields are derived from the parameters, not hard-coded.

Per-opcode control:
- **R-type (opcode 0):**
  - alu_ctrl = funct; wr_addr = rd.
  - reg_write = 1, except funct 0x08 (JR).
- **I-type:**
  - alu_ctrl = opcode; wr_addr = rt.
  - reg_write = 1 for opcodes 0x08–0x0F and 0x23.
  - mem_read = (opcode == 0x23); mem_write = (opcode == 0x2B).
- **Immediate extension:**
  - zero-extend for opcodes 0x0C–0x0F (ANDI/ORI/XORI/LUI);
  - sign-extend for all other opcodes.

Register file:
- 2**NB_ADDR × NB_DATA; register 0 always reads 0 and ignores writes.
- Write occurs when i_wb_wr_enable && i_wb_wr_addr != 0.
- Read bypass: same-cycle reads of the address being written return i_wb_data.
- i_reset clears all entries.

Hazard detection:
- o_stall = i_valid && i_ex_reg_write && i_ex_wr_addr != 0 && i_ex_wr_addr ∈ {rs, rt} && (i_ex_mem_read || opcode ∈ {BEQ 0x04, BNE 0x05}).
- Forcing o_stall to 0 when i_valid is 0 is required.

Branch resolution:
- o_branch_taken = i_valid && !o_stall && !i_flush && ((BEQ && rs_data == rt_data) || (BNE && rs_data != rt_data)).
- Comparison uses the bypassed register-file data.

ID/EX register update priority:
1. i_reset: all outputs 0.
2. i_flush or o_stall: insert a bubble; all ID/EX outputs are zeroed.
3. Otherwise: load the decoded values, with o_valid = i_valid.
   - When i_valid = 0, the control outputs (reg_write, mem_read, mem_write) are forced to 0.

## Timing
- Reset value of every registered output is 0; o_stall, o_branch_taken and o_branch_target are combinational and depend only on current inputs.
- ID/EX outputs are valid 1 cycle after the instruction is presented on IF/ID.
- A load-use stall lasts exactly 1 cycle:
  - the next cycle EX holds the bubble, so i_ex_reg_write = 0 and the stall releases.
- BEQ/BNE directly following a dependent non-load ALU instruction stalls 1 cycle. It then resolves against the bypassed writeback value, assuming MEM-to-WB timing supplies it.
- Writeback and read of the same register in the same cycle: the read returns the new data.
- Writeback to r0 simultaneously with a read of r0: the read returns 0.
- Flush and stall in the same cycle: bubble (same result either way); o_branch_taken = 0.
- Reset asserted mid-stall: outputs 0 on the next edge; the register file is cleared.

## Structure
- Package `decode_pkg` holds:
  - opcode constants: R_TYPE, BEQ, BNE, ADDI…LUI, LW, SW;
  - funct constant JR;
  - field-position localparams derived from NB_DATA/NB_OPCODE/NB_ADDR.
- Sub-module `register_file_bypass` provides 2 read ports, 1 write port, r0 hardwiring, the write-through bypass and synchronous clear. The top level contains the decode, hazard, branch and ID/EX logic.

## Test plan
- **Reset:** hold i_reset 2 cycles → all outputs 0; a subsequent read of r5 returns 0.
- **ADDI with negative immediate:** write r1 = 0x10 via WB, then issue ADDI r2, r1, 0xFFFC → after 1 cycle, o_rs_data = 0x10, o_imm = 0xFFFFFFFC, o_wr_addr = 2, o_reg_write = 1. ORI with 0xFFFC → o_imm = 0x0000FFFC.
- **Load-use:** LW r3 in EX (i_ex_mem_read = 1, i_ex_wr_addr = 3), ID holds ADD r4, r3, r5 → o_stall = 1 and the next o_valid = 0. Next cycle, with i_ex_reg_write = 0 → o_stall = 0 and ADD is latched.
- **Write-through:** WB writes r7 = 0xA5A5A5A5 in the same cycle ID reads rs = 7 → o_rs_data = 0xA5A5A5A5. A WB write to r0 → reads of r0 stay 0.
- **Branch:** r1 = r2 = 9, BEQ r1, r2, imm = 3, i_pc = 0x100 → o_branch_taken = 1, o_branch_target = 0x10C. BNE with the same operands → taken = 0.
- **Flush:** i_flush with a valid SW → next cycle o_valid = 0, o_mem_write = 0, o_branch_taken = 0.
